adder_arbiter: RTL and testbench

Round-robin arbiter that shares the single 24-bit mantissa adder (adder_24b) among N_REQ requesters (the adder controller, the multiplier controller, and others) over REQ/ACK handshakes. It sits between the requester controllers and the adder's callee interface. It registers the winning request's operands, runs one adder transaction at a time, and returns the sum and carry to the winner with a single-cycle acknowledge.

---
 rtl/fpu_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/adder_arbiter.sv | 146 ++++++++++++++
 tb/tb_adder_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the mantissa-adder arbiter.
package fpu_arb_pkg;

  localparam int ADDER_W     = 24;
  localparam int TIMEOUT_DEF = 64;
  localparam int WD_W        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: rotate requests by ptr, take the lowest set
// bit, rotate the index back. Outputs one-hot grant and encoded index.
module rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  int                 off_s;
  int                 sum_s;

  // Rotate, priority-select, rotate back.
  always_comb begin
    dbl_s = {req_i, req_i} >> ptr_i;
    rot_s = dbl_s[N_REQ-1:0];
    off_s = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = i;
      end else begin
        off_s = off_s;
      end
    end
    sum_s = int'(ptr_i) + off_s;
    if (sum_s >= N_REQ) begin
      sum_s = sum_s - N_REQ;
    end else begin
      sum_s = sum_s;
    end
    idx_o   = IDX_W'(sum_s);
    valid_o = |req_i;
    grant_o = valid_o ? (N_REQ'(1'b1) << idx_o) : '0;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of the 24-bit mantissa adder among N_REQ requesters.
// Optional ISSUE-state watchdog enabled by defining ADDER_ARB_TIMEOUT_EN.
module adder_arbiter
  import fpu_arb_pkg::*;
#(
  parameter  int N_REQ          = 2,
  parameter  int WIDTH          = ADDER_W,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_DEF,
  localparam int IDX_W          = $clog2(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] Datain1,
  input  logic [N_REQ*WIDTH-1:0] Datain2,
  output logic [N_REQ-1:0]       Ack,
  output logic [WIDTH-1:0]       Dataout,
  output logic                   Carryout,
  output logic                   Err,
  output logic                   Busy,
  output logic [IDX_W-1:0]       Grant_id,
  output logic [WIDTH-1:0]       Adder_datain1,
  output logic [WIDTH-1:0]       Adder_datain2,
  output logic                   Adder_valid,
  input  logic [WIDTH-1:0]       Adder_dataout,
  input  logic                   Adder_carryout,
  input  logic                   Adder_ack
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gid_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] ack_q;
  logic [WIDTH-1:0] dout_q;
  logic             cout_q;
  logic             err_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;

  logic [N_REQ-1:0] win_gnt_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             any_req_s;

  // Watchdog limit must fit the 8-bit counter; out-of-range values are left visible here.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_timeout_out_of_range
  end

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i   (Req),
    .ptr_i   (ptr_q),
    .grant_o (win_gnt_s),
    .idx_o   (win_idx_s),
    .valid_o (any_req_s)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
`ifdef ADDER_ARB_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (any_req_s) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            gid_q   <= win_idx_s;
            gnt_q   <= win_gnt_s;
            op_a_q  <= Datain1[win_idx_s*WIDTH +: WIDTH];
            op_b_q  <= Datain2[win_idx_s*WIDTH +: WIDTH];
`ifdef ADDER_ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
        end
        ISSUE: begin
          if (Adder_ack) begin
            dout_q  <= Adder_dataout;
            cout_q  <= Adder_carryout;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= gnt_q;
            state_q <= RESP;
`ifdef ADDER_ARB_TIMEOUT_EN
          end else if (wd_q == WD_LIMIT) begin
            dout_q  <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            ack_q   <= gnt_q;
            state_q <= RESP;
          end else begin
            wd_q    <= wd_q + WD_W'(1);
`endif
          end
        end
        RESP: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= IDX_W'(rr_next(int'(gid_q), N_REQ));
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Ack           = ack_q;
  assign Dataout       = dout_q;
  assign Carryout      = cout_q;
  assign Err           = err_q;
  assign Busy          = busy_q;
  assign Grant_id      = gid_q;
  assign Adder_datain1 = op_a_q;
  assign Adder_datain2 = op_b_q;
  assign Adder_valid   = valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (N_REQ=2) with a 1-cycle adder stub.
// Watchdog expectations follow ADDER_ARB_TIMEOUT_EN.
module tb_adder_arbiter;

  localparam int N = 2;
  localparam int W = 24;

  logic           CLK = 1'b0;
  logic           RSTn;
  logic [N-1:0]   Req = '0;
  logic [N*W-1:0] Datain1 = '0;
  logic [N*W-1:0] Datain2 = '0;
  logic [N-1:0]   Ack;
  logic [W-1:0]   Dataout;
  logic           Carryout;
  logic           Err;
  logic           Busy;
  logic [0:0]     Grant_id;
  logic [W-1:0]   Adder_datain1;
  logic [W-1:0]   Adder_datain2;
  logic           Adder_valid;
  logic [W-1:0]   Adder_dataout;
  logic           Adder_carryout;
  logic           Adder_ack;

  logic           stub_ack  = 1'b0;
  logic [W-1:0]   stub_dout = '0;
  logic           stub_cout = 1'b0;
  bit             adder_en  = 1'b1;
  logic           idle_ack  = 1'b0;

  int errs   = 0;
  int checks = 0;
  int cyc;
  bit got;

  assign Adder_ack      = stub_ack | idle_ack;
  assign Adder_dataout  = idle_ack ? 24'hFFFFFF : stub_dout;
  assign Adder_carryout = idle_ack ? 1'b1 : stub_cout;

  adder_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .Req            (Req),
    .Datain1        (Datain1),
    .Datain2        (Datain2),
    .Ack            (Ack),
    .Dataout        (Dataout),
    .Carryout       (Carryout),
    .Err            (Err),
    .Busy           (Busy),
    .Grant_id       (Grant_id),
    .Adder_datain1  (Adder_datain1),
    .Adder_datain2  (Adder_datain2),
    .Adder_valid    (Adder_valid),
    .Adder_dataout  (Adder_dataout),
    .Adder_carryout (Adder_carryout),
    .Adder_ack      (Adder_ack)
  );

  initial forever #5 CLK = ~CLK;

  // Adder stub: answers a valid request one cycle later with a single-cycle ACK.
  initial forever begin
    @(posedge CLK);
    #1;
    if (adder_en && Adder_valid && !stub_ack) begin
      {stub_cout, stub_dout} = {1'b0, Adder_datain1} + {1'b0, Adder_datain2};
      stub_ack = 1'b1;
    end else begin
      stub_ack = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    Datain1[r*W +: W] = a;
    Datain2[r*W +: W] = b;
  endtask

  task automatic wait_ack(input int budget, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge CLK);
      n++;
      if (|Ack) seen = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"},   32'(Ack),           32'd0);
    chk({tag, "_dout"},  32'(Dataout),       32'd0);
    chk({tag, "_cout"},  32'(Carryout),      32'd0);
    chk({tag, "_err"},   32'(Err),           32'd0);
    chk({tag, "_busy"},  32'(Busy),          32'd0);
    chk({tag, "_gid"},   32'(Grant_id),      32'd0);
    chk({tag, "_valid"}, 32'(Adder_valid),   32'd0);
    chk({tag, "_a1"},    32'(Adder_datain1), 32'd0);
    chk({tag, "_a2"},    32'(Adder_datain2), 32'd0);
  endtask

  initial begin
    RSTn = 1'b1;
    #1 RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    check_zero("rst");
    RSTn = 1'b1;
    @(negedge CLK);

    // Single request from requester 0: 2.75 + 2.75
    set_op(0, 24'hB00000, 24'hB00000);
    Req = 2'b01;
    @(negedge CLK);
    chk("t1_busy",  32'(Busy),          32'd1);
    chk("t1_valid", 32'(Adder_valid),   32'd1);
    chk("t1_gid",   32'(Grant_id),      32'd0);
    chk("t1_a1",    32'(Adder_datain1), 32'hB00000);
    chk("t1_a2",    32'(Adder_datain2), 32'hB00000);
    wait_ack(8, cyc, got);
    chk("t1_got",  32'(got),      32'd1);
    chk("t1_lat",  32'(cyc),      32'd1);
    chk("t1_ack",  32'(Ack),      32'b01);
    chk("t1_dout", 32'(Dataout),  32'h600000);
    chk("t1_cout", 32'(Carryout), 32'd1);
    chk("t1_err",  32'(Err),      32'd0);
    Req = 2'b00;
    @(negedge CLK);
    chk("t1_ack_drop", 32'(Ack),  32'd0);
    chk("t1_idle",     32'(Busy), 32'd0);

    // Single request from requester 1 brings the pointer back to 0
    set_op(1, 24'hB00000, 24'h580000);
    Req = 2'b10;
    wait_ack(8, cyc, got);
    chk("t2_got",  32'(got),      32'd1);
    chk("t2_lat",  32'(cyc),      32'd2);
    chk("t2_ack",  32'(Ack),      32'b10);
    chk("t2_gid",  32'(Grant_id), 32'd1);
    chk("t2_dout", 32'(Dataout),  32'h080000);
    chk("t2_cout", 32'(Carryout), 32'd1);
    Req = 2'b00;
    @(negedge CLK);

    // Simultaneous requests with ptr=0: 0 first, idle cycle, then 1
    set_op(0, 24'h000001, 24'h000002);
    set_op(1, 24'hFFFFFF, 24'h000001);
    Req = 2'b11;
    wait_ack(8, cyc, got);
    chk("t3a_got",  32'(got),      32'd1);
    chk("t3a_lat",  32'(cyc),      32'd2);
    chk("t3a_ack",  32'(Ack),      32'b01);
    chk("t3a_dout", 32'(Dataout),  32'h000003);
    chk("t3a_cout", 32'(Carryout), 32'd0);
    Req = 2'b10;
    @(negedge CLK);
    chk("t3_gap_ack",  32'(Ack),  32'd0);
    chk("t3_gap_busy", 32'(Busy), 32'd0);
    wait_ack(8, cyc, got);
    chk("t3b_got",  32'(got),      32'd1);
    chk("t3b_lat",  32'(cyc),      32'd2);
    chk("t3b_ack",  32'(Ack),      32'b10);
    chk("t3b_gid",  32'(Grant_id), 32'd1);
    chk("t3b_dout", 32'(Dataout),  32'h000000);
    chk("t3b_cout", 32'(Carryout), 32'd1);
    Req = 2'b00;
    @(negedge CLK);

    // Both requests held for six transactions: strict alternation
    Req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_ack(10, cyc, got);
      chk("t4_got", 32'(got),      32'd1);
      chk("t4_lat", 32'(cyc),      (k == 0) ? 32'd2 : 32'd3);
      chk("t4_gid", 32'(Grant_id), 32'(k % 2));
      chk("t4_ack", 32'(Ack),      32'(1 << (k % 2)));
    end
    Req = 2'b00;
    @(negedge CLK);

    // Serve requester 0 so the pointer sits at 1 before the reset test
    set_op(0, 24'h7FFFFF, 24'h000001);
    Req = 2'b01;
    wait_ack(8, cyc, got);
    chk("t5p_got",  32'(got),      32'd1);
    chk("t5p_dout", 32'(Dataout),  32'h800000);
    chk("t5p_cout", 32'(Carryout), 32'd0);
    Req = 2'b00;
    @(negedge CLK);

    // Asynchronous reset in the middle of ISSUE
    adder_en = 1'b0;
    set_op(1, 24'h123456, 24'h654321);
    Req = 2'b10;
    @(negedge CLK);
    chk("t5_valid", 32'(Adder_valid), 32'd1);
    chk("t5_gid",   32'(Grant_id),    32'd1);
    #2 RSTn = 1'b0;
    #1 check_zero("rst_mid");
    Req = 2'b00;
    @(negedge CLK);
    RSTn = 1'b1;
    wait_ack(5, cyc, got);
    chk("t5_no_ack", 32'(got),  32'd0);
    chk("t5_busy",   32'(Busy), 32'd0);
    adder_en = 1'b1;
    set_op(0, 24'h000010, 24'h000020);
    Req = 2'b11;
    wait_ack(8, cyc, got);
    chk("t5r_got",  32'(got),      32'd1);
    chk("t5r_lat",  32'(cyc),      32'd2);
    chk("t5r_gid",  32'(Grant_id), 32'd0);
    chk("t5r_ack",  32'(Ack),      32'b01);
    chk("t5r_dout", 32'(Dataout),  32'h000030);
    Req = 2'b00;
    @(negedge CLK);

    // Adder ACK while IDLE must be ignored
    idle_ack = 1'b1;
    @(negedge CLK);
    chk("t6_ack",   32'(Ack),         32'd0);
    chk("t6_busy",  32'(Busy),        32'd0);
    chk("t6_valid", 32'(Adder_valid), 32'd0);
    chk("t6_dout",  32'(Dataout),     32'h000030);
    idle_ack = 1'b0;
    @(negedge CLK);
    chk("t6_ack2",  32'(Ack),  32'd0);
    chk("t6_busy2", 32'(Busy), 32'd0);

    // Adder never answers
    adder_en = 1'b0;
    set_op(0, 24'h000001, 24'h000001);
    Req = 2'b01;
`ifdef ADDER_ARB_TIMEOUT_EN
    wait_ack(100, cyc, got);
    chk("t7_got",  32'(got),      32'd1);
    chk("t7_lat",  32'(cyc),      32'd65);
    chk("t7_ack",  32'(Ack),      32'b01);
    chk("t7_err",  32'(Err),      32'd1);
    chk("t7_dout", 32'(Dataout),  32'd0);
    chk("t7_cout", 32'(Carryout), 32'd0);
    Req = 2'b00;
    @(negedge CLK);
    chk("t7_ack_drop", 32'(Ack),  32'd0);
    chk("t7_idle",     32'(Busy), 32'd0);
`else
    wait_ack(200, cyc, got);
    chk("t7_no_ack", 32'(got),         32'd0);
    chk("t7_busy",   32'(Busy),        32'd1);
    chk("t7_valid",  32'(Adder_valid), 32'd1);
    chk("t7_err",    32'(Err),         32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
